// File: rtl/data_mem_responder.sv
// Word-organised data RAM serving one sized load/store at a time for the RISC-V datapath.
// Latency: ready pulses in the cycle after edge accept+LATENCY+1; one request per LATENCY+3 cycles.
// Backpressure: busy is high outside IDLE; strobes seen while busy are dropped, not queued.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          store_q;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   word_rd, shifted, ldata, wmerge;
  logic          err;
  logic          unused_addr;

  // Addresses wrap modulo 4*DEPTH, so the upper address bits are never stored.
  assign unused_addr = ^addr[31:AW+2];
  assign idx         = addr_q[AW+1:2];
  assign word_rd     = mem[idx];
  assign shifted     = word_rd >> {addr_q[1:0], 3'b000};

  always_comb begin
    err = 1'b0;
    case (f3_q)
      3'd0:    err = 1'b0;
      3'd1:    err = addr_q[0];
      3'd2:    err = |addr_q[1:0];
      3'd4:    err = store_q;
      3'd5:    err = store_q | addr_q[0];
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    ldata = '0;
    case (f3_q)
      3'd0:    ldata = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    ldata = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    ldata = word_rd;
      3'd4:    ldata = {24'd0, shifted[7:0]};
      3'd5:    ldata = {16'd0, shifted[15:0]};
      default: ldata = '0;
    endcase
  end

  // Read-modify-write merge keeps unselected byte lanes intact.
  always_comb begin
    wmerge = word_rd;
    case (f3_q)
      3'd0:    wmerge[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      3'd1:    wmerge[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      3'd2:    wmerge = wdata_q;
      default: wmerge = word_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      store_q    <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemRead | MemWrite) begin
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            f3_q    <= funct3;
            store_q <= MemWrite;
            cnt     <= 4'(LATENCY);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (store_q && !err) mem[idx] <= wmerge;
            rdata      <= (!store_q && !err) ? ldata : 32'd0;
            misaligned <= err;
            ready      <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          rdata      <= '0;
          misaligned <= 1'b0;
          ready      <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected responses queued at issue, checked by a monitor.
module tb_data_mem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  funct3 = '0;
  logic        busy, ready, misaligned;
  logic [31:0] rdata;

  int checks = 0;
  int fails = 0;
  int accepted = 0;
  int readies = 0;
  bit done = 1'b0;

  logic [31:0] exp_rd_q[$];
  logic        exp_mis_q[$];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .busy(busy), .ready(ready), .rdata(rdata), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ready pulse; outputs must be zero outside ready.
  initial begin
    logic        prev_ready;
    logic [31:0] er;
    logic        em;
    prev_ready = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ready) begin
        readies++;
        check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
        if (exp_rd_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ready: got ready with empty scoreboard");
        end else begin
          er = exp_rd_q.pop_front();
          em = exp_mis_q.pop_front();
          check("rdata", rdata, er);
          check("misaligned", {31'd0, misaligned}, {31'd0, em});
        end
      end else begin
        check("idle_rdata_zero", rdata, 32'd0);
        check("idle_misaligned_zero", {31'd0, misaligned}, 32'd0);
      end
      prev_ready = ready;
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] er, input logic em, input bit noise);
    int n;
    int k;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: busy stuck high after %0d cycles", n);
    end
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = wd;
    funct3   = f3;
    exp_rd_q.push_back(er);
    exp_mis_q.push_back(em);
    accepted++;
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    k = 0;
    while (!ready && k < 50) begin
      if (noise) begin
        MemRead = ~MemRead;
        addr    = 32'h4;
        funct3  = 3'd2;
      end
      @(negedge clk);
      k++;
    end
    MemRead = 1'b0;
    check("ready_latency", k, LATENCY + 1);
    @(negedge clk);
    check("busy_after_resp", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store aborted by reset in the middle of WAIT.
    MemWrite = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; funct3 = 3'd2;
    @(negedge clk);
    MemWrite = 1'b0;
    check("abort_busy_before_reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_misaligned", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1, 0, 32'h10, 0, 3'd2, 32'h0000_0000, 0, 0);

    // Word round trip.
    do_req(0, 1, 32'h8, 32'hDEAD_BEEF, 3'd2, 32'h0, 0, 0);
    do_req(1, 0, 32'h8, 0, 3'd2, 32'hDEAD_BEEF, 0, 0);

    // Sub-word stores and loads.
    do_req(0, 1, 32'h4, 32'h1122_3344, 3'd2, 32'h0, 0, 0);
    do_req(0, 1, 32'h6, 32'h0000_00AA, 3'd0, 32'h0, 0, 0);
    do_req(1, 0, 32'h4, 0, 3'd2, 32'h11AA_3344, 0, 0);
    do_req(1, 0, 32'h6, 0, 3'd0, 32'hFFFF_FFAA, 0, 0);
    do_req(1, 0, 32'h6, 0, 3'd4, 32'h0000_00AA, 0, 0);
    do_req(1, 0, 32'h6, 0, 3'd1, 32'h0000_11AA, 0, 0);
    do_req(1, 0, 32'h4, 0, 3'd5, 32'h0000_3344, 0, 0);
    do_req(0, 1, 32'h1A, 32'h1234_8001, 3'd1, 32'h0, 0, 0);
    do_req(1, 0, 32'h1A, 0, 3'd1, 32'hFFFF_8001, 0, 0);
    do_req(1, 0, 32'h1B, 0, 3'd0, 32'hFFFF_FF80, 0, 0);
    do_req(1, 0, 32'h18, 0, 3'd2, 32'h8001_0000, 0, 0);

    // Error cases leave memory untouched.
    do_req(0, 1, 32'h2, 32'h5555_5555, 3'd2, 32'h0, 1, 0);
    do_req(1, 0, 32'h0, 0, 3'd2, 32'h0000_0000, 0, 0);
    do_req(1, 0, 32'h1, 0, 3'd1, 32'h0, 1, 0);
    do_req(1, 0, 32'h0, 0, 3'd3, 32'h0, 1, 0);
    do_req(0, 1, 32'h8, 32'h0, 3'd4, 32'h0, 1, 0);
    do_req(1, 0, 32'h8, 0, 3'd2, 32'hDEAD_BEEF, 0, 0);

    // Address wrap, then strobes toggling during WAIT.
    do_req(0, 1, 32'h400, 32'h1234_5678, 3'd2, 32'h0, 0, 0);
    do_req(1, 0, 32'h0, 0, 3'd2, 32'h1234_5678, 0, 1);

    // Both strobes high behaves as a store.
    do_req(1, 1, 32'hC, 32'hCAFE_F00D, 3'd2, 32'h0, 0, 0);
    do_req(1, 0, 32'hC, 0, 3'd2, 32'hCAFE_F00D, 0, 0);

    repeat (8) @(negedge clk);
    check("ready_count", readies, accepted);
    check("scoreboard_empty", exp_rd_q.size(), 0);
    done = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the RISC-V datapath: it serves the load/store requests driven by the control unit's MemRead/MemWrite strobes, together with the ALU-computed address, the store data and the instruction funct3. It holds a word-organised RAM and services one request at a time after a configurable number of wait cycles. It returns sized, sign- or zero-extended load data and a one-cycle ready pulse. Misaligned and illegal-size accesses are flagged and have no effect on memory.

## Interface
- DEPTH, 256: RAM size in 32-bit words; power of two, 4..4096.
- LATENCY, 2: wait cycles between accept and response; 0..15.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead  in  1  load request strobe.
- MemWrite  in  1  store request strobe.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte/half is used for sb/sh.
- funct3  in  3  access size/sign: 0 b, 1 h, 2 w, 4 bu, 5 hu.
- busy  out  1  high whenever state is not IDLE.
- ready  out  1  one-cycle response pulse.
- rdata  out  32  load result; valid only while ready=1, otherwise 0.
- misaligned  out  1  error flag; valid only while ready=1, otherwise 0.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: a request is accepted on a rising edge where MemRead|MemWrite=1.
  - addr, wdata, funct3 and the op type are registered.
  - The counter is loaded with LATENCY and the FSM goes to WAIT.
  - If MemRead and MemWrite are both high, the request is a store and rdata stays 0.
- WAIT:
  - Counter=0: the next edge goes to RESP, and the store write happens on that same edge.
  - Counter≠0: the counter decrements on each edge.
- RESP: ready=1 for this cycle only; the next edge returns to IDLE.
- Requests are not accepted in WAIT or RESP. Inputs are ignored there and strobes are not queued.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo 4*DEPTH.
  - Byte lanes are little-endian: byte n = bits [8n+7:8n].
- Loads:
  - lb sign-extends the selected byte; lbu zero-extends it.
  - lh sign-extends the selected half; lhu zero-extends it.
  - lw returns the whole word.
- Stores:
  - sb writes only the selected byte lane.
  - sh writes only the selected half.
  - sw writes the whole word.
  - Unselected lanes are preserved.
- Error case: misaligned=1 in RESP when any of the following holds:
  - a half access with addr[0]=1;
  - a word access with addr[1:0]≠0;
  - funct3 = 3, 6 or 7;
  - funct3 = 4 or 5 on a store.
- On error: no memory change, rdata=0, and ready still pulses.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, counter=0;
  - busy=0, ready=0, rdata=0, misaligned=0;
  - all RAM words cleared to 0.
- Reset mid-operation aborts the request. A store not yet written (reset before the WAIT→RESP edge) never takes effect.
- Latency: accept at edge E0; ready is high during the cycle after edge E0+LATENCY+1.
- busy rises after E0 and falls after edge E0+LATENCY+2.
- Store data is readable by any later request. The earliest next accept is edge E0+LATENCY+3, which gives a request interval of LATENCY+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rdata and misaligned are launched on the edge entering RESP and return to 0 on the edge leaving it.

## Test plan
- Reset then idle:
  - Assert rst_n=0 mid-WAIT of a sw to 0x10 -> busy/ready/rdata/misaligned are 0 immediately.
  - After release, lw 0x10 -> rdata=0x00000000.
- Word round trip, LATENCY=2:
  - sw 0x8 with wdata=0xDEADBEEF accepted at E0 -> ready high only after E3, misaligned=0.
  - Then lw 0x8 -> rdata=0xDEADBEEF.
- Sub-word:
  - Start from word 0x11223344 at 0x4, then sb 0x6 with wdata=0x000000AA -> word becomes 0x11AA3344.
  - lb 0x6 -> 0xFFFFFFAA; lbu 0x6 -> 0x000000AA.
  - lh 0x6 -> 0x000011AA; lhu 0x4 -> 0x00003344.
- Errors:
  - sw 0x2 -> misaligned=1 and memory unchanged.
  - lh 0x1 -> misaligned=1, rdata=0.
  - funct3=3 load -> misaligned=1.
- Wrap and busy, DEPTH=256:
  - sw 0x400 with 0x12345678 then lw 0x0 -> 0x12345678.
  - MemRead pulses during WAIT are ignored: exactly one ready per accepted request.
- Both strobes high: MemRead=MemWrite=1, sw 0xC with 0xCAFEF00D -> rdata=0 at ready; a later lw 0xC -> 0xCAFEF00D.
